reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
Circular in-order reorder buffer for the Tomasulo RV32I core. It allocates a tag per decoded instruction and captures CDB results out of order. It retires one entry per cycle into the register file (data_valid/reg_dest/tag/data) and to the load-store buffer (store release). On commit of a mispredicted branch it raises the global clear with the redirect PC. Two combinational operand-query ports let dispatch bypass results that are finished but not yet committed.

Parameters:
DEPTH, 16, number of entries (power of two)
TAG_W, 4, tag width = log2(DEPTH); tag = entry index
DATA_W, 32, result/PC width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = freeze all state
id_valid  in  1  allocate request from decode
id_reg_dest  in  5  destination register; 0 = none
id_is_store  in  1  entry is a store
id_is_branch  in  1  entry is a conditional branch/JALR
id_pred_taken  in  1  fetch prediction
alloc_tag  out  TAG_W  tag granted to current id request (= tail)
full  out  1  no allocation accepted this cycle
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  producing entry
cdb_data  in  DATA_W  result value; for branches, correct next PC
cdb_taken  in  1  branch outcome (ignored for non-branch)
q1_tag, q2_tag  in  TAG_W  operand query tags from dispatch
q1_ready, q2_ready  out  1  tag's result available
q1_data, q2_data  out  DATA_W  that result
commit_valid  out  1  retire pulse to regfile
commit_reg_dest  out  5  retired destination
commit_tag  out  TAG_W  retired tag
commit_data  out  DATA_W  retired value
commit_store  out  1  pulse: head store may write memory
clear  out  1  one-cycle global flush
clear_pc  out  DATA_W  redirect PC, valid while clear=1

Behaviour:
- Reset (rst=1 at posedge): head=tail=count=0, all entry ready bits 0, state RUN. All registered outputs 0: commit_*, clear, clear_pc. rst dominates rdy and everything else, including mid-flush.
- rdy=0: no state or output register changes.
- Entry fields: busy, ready, reg_dest, is_store, is_branch, pred_taken, taken, data.
- full = (count==DEPTH) || state!=RUN (combinational). alloc_tag = tail.
- Allocation (RUN, id_valid && !full): write entry[tail] with busy=1, ready=0; tail+1 mod DEPTH. A full buffer drops the request; decode holds and retries.
- CDB (RUN, cdb_valid): entry[cdb_tag].ready=1, data and taken captured. A write to a non-busy tag is ignored.
- Commit (RUN, count>0, entry[head].ready): registered one-cycle pulse next cycle.
  - commit_valid=1 with reg_dest, tag=head, data.
  - commit_store=1 if is_store.
  - Entry freed; head+1 mod DEPTH.
  - A CDB write to the head entry commits no earlier than the following edge: ready is a registered bit.
- Count: count += alloc - commit. Simultaneous alloc and commit leaves count unchanged. Allocation into a slot freed on the same edge is not allowed, because full is evaluated before the edge.
- Pointers wrap DEPTH-1 -> 0 with no gap.
- Misprediction: committing a branch with taken != pred_taken moves RUN -> FLUSH.
  - The commit pulse is still emitted, so a JALR rd write reaches the regfile before clear.
- FLUSH (1 cycle):
  - No commit, allocation or CDB capture.
  - Next edge: clear=1, clear_pc=branch data, head=tail=count=0, all busy/ready cleared, state CLEAR.
- CLEAR (1 cycle): inputs ignored; next edge clear=0, state RUN.
- Query (combinational, per port):
  - If cdb_valid && cdb_tag==qN_tag: ready=1, data=cdb_data.
  - Else: ready=entry.ready, data=entry.data.
  - Unbusy tag: ready=0, data=0.
- Non-pulse outputs not updated in a cycle return to 0 (commit_valid, commit_store, clear are single-cycle pulses).

Decomposition:
- Shared cpu_define package: DataBus, RegBus, TagBus widths; Valid/Invalid/Busy/Free/Null constants; ROB state encodings RUN/FLUSH/CLEAR.
- One sub-module is natural: rob_query, the combinational tag lookup with CDB bypass, instantiated twice.

Test Plan:
- Allocate three entries: x1 tag0, x2 tag1, store tag2. CDB order tag1=0x22, tag2, tag0=0x11. Required: commits in order tag0 (x1=0x11), tag1 (x2=0x22), then commit_store pulse, each one cycle apart after tag0 ready.
- Allocate 16 with no results: full=1 and the 17th id_valid is dropped (tail stays 0). Complete tag0: commit next cycle, then full=0 and alloc_tag=0 (wrap).
- Branch tag3 with pred_taken=0; CDB tag3 taken=1, data=0x1000. Required: commit pulse, then FLUSH, then clear=1 with clear_pc=0x1000 for exactly one cycle; count=0 afterwards and alloc_tag=0.
- q1_tag=5 with cdb_valid, cdb_tag=5, data=0xABCD in the same cycle: q1_ready=1, q1_data=0xABCD combinationally. Next cycle without CDB: still ready from the entry.
- rdy=0 for 3 cycles with cdb_valid and id_valid pulsed: no state change; resumes identically when rdy=1.
- Assert rst during FLUSH: clear never asserts, all outputs 0, count 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, constants and state encodings for the reorder buffer and its helpers.
package reorder_buffer_pkg;

    localparam int unsigned DataBus  = 32;
    localparam int unsigned RegBus   = 5;
    localparam int unsigned TagBus   = 4;
    localparam int unsigned RobDepth = 16;

    localparam logic Valid   = 1'b1;
    localparam logic Invalid = 1'b0;
    localparam logic Busy    = 1'b1;
    localparam logic Free    = 1'b0;

    localparam logic [DataBus-1:0] Null = '0;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StClear
    } rob_state_e;

endpackage

// File: rtl/reorder_buffer_query.sv
// Operand lookup by tag, with a same-cycle bypass from the CDB broadcast.
module reorder_buffer_query
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = RobDepth,
    parameter int unsigned TAG_W  = TagBus,
    parameter int unsigned DATA_W = DataBus
) (
    input  logic [TAG_W-1:0]  q_tag_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    input  logic [DEPTH-1:0]  busy_i,
    input  logic [DEPTH-1:0]  ready_i,
    input  logic [DATA_W-1:0] data_i [DEPTH],
    output logic              q_ready_o,
    output logic [DATA_W-1:0] q_data_o
);

    always_comb begin
        q_ready_o = Invalid;
        q_data_o  = DATA_W'(Null);
        if (busy_i[q_tag_i] == Busy) begin
            if (cdb_valid_i && (cdb_tag_i == q_tag_i)) begin
                q_ready_o = Valid;
                q_data_o  = cdb_data_i;
            end else begin
                q_ready_o = ready_i[q_tag_i];
                q_data_o  = data_i[q_tag_i];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, captures CDB results,
// retires one entry per cycle and raises a global clear on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = RobDepth,
    parameter int unsigned TAG_W  = TagBus,
    parameter int unsigned DATA_W = DataBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              id_valid,
    input  logic [RegBus-1:0] id_reg_dest,
    input  logic              id_is_store,
    input  logic              id_is_branch,
    input  logic              id_pred_taken,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic              full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_taken,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_data,
    output logic [DATA_W-1:0] q2_data,
    output logic              commit_valid,
    output logic [RegBus-1:0] commit_reg_dest,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_store,
    output logic              clear,
    output logic [DATA_W-1:0] clear_pc
);

    localparam logic [TAG_W:0] FullCount = (TAG_W + 1)'(DEPTH);

    rob_state_e        state_q;
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [DATA_W-1:0] flush_pc_q;

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  ready_q;
    logic [DEPTH-1:0]  is_store_q;
    logic [DEPTH-1:0]  is_branch_q;
    logic [DEPTH-1:0]  pred_q;
    logic [DEPTH-1:0]  taken_q;
    logic [RegBus-1:0] reg_dest_q [DEPTH];
    logic [DATA_W-1:0] data_q     [DEPTH];

    logic do_alloc, do_cdb, do_commit, mispredict;

    assign full       = (count_q == FullCount) || (state_q != StRun);
    assign alloc_tag  = tail_q;
    assign do_alloc   = (state_q == StRun) && id_valid && !full;
    assign do_cdb     = (state_q == StRun) && cdb_valid && (busy_q[cdb_tag] == Busy);
    assign do_commit  = (state_q == StRun) && (count_q != '0) && ready_q[head_q];
    assign mispredict = do_commit && is_branch_q[head_q] && (taken_q[head_q] != pred_q[head_q]);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (state_q == StFlush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_alloc)  tail_d = tail_q + TAG_W'(1);
            if (do_commit) head_d = head_q + TAG_W'(1);
            count_d = count_q + {{TAG_W{1'b0}}, do_alloc} - {{TAG_W{1'b0}}, do_commit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StRun;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            ready_q         <= '0;
            flush_pc_q      <= '0;
            commit_valid    <= Invalid;
            commit_store    <= Invalid;
            commit_reg_dest <= '0;
            commit_tag      <= '0;
            commit_data     <= '0;
            clear           <= Invalid;
            clear_pc        <= '0;
        end else if (rdy) begin
            commit_valid    <= Invalid;
            commit_store    <= Invalid;
            commit_reg_dest <= '0;
            commit_tag      <= '0;
            commit_data     <= '0;
            clear           <= Invalid;
            clear_pc        <= '0;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            case (state_q)
                StRun: begin
                    if (do_alloc) begin
                        busy_q[tail_q]      <= Busy;
                        ready_q[tail_q]     <= Invalid;
                        reg_dest_q[tail_q]  <= id_reg_dest;
                        is_store_q[tail_q]  <= id_is_store;
                        is_branch_q[tail_q] <= id_is_branch;
                        pred_q[tail_q]      <= id_pred_taken;
                    end
                    if (do_cdb) begin
                        ready_q[cdb_tag] <= Valid;
                        data_q[cdb_tag]  <= cdb_data;
                        taken_q[cdb_tag] <= cdb_taken;
                    end
                    // Placed after the CDB capture so a freed head cannot be re-marked ready.
                    if (do_commit) begin
                        commit_valid    <= Valid;
                        commit_store    <= is_store_q[head_q];
                        commit_reg_dest <= reg_dest_q[head_q];
                        commit_tag      <= head_q;
                        commit_data     <= data_q[head_q];
                        busy_q[head_q]  <= Free;
                        ready_q[head_q] <= Invalid;
                        if (mispredict) begin
                            state_q    <= StFlush;
                            flush_pc_q <= data_q[head_q];
                        end
                    end
                end
                StFlush: begin
                    clear    <= Valid;
                    clear_pc <= flush_pc_q;
                    busy_q   <= '0;
                    ready_q  <= '0;
                    state_q  <= StClear;
                end
                StClear: state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

    reorder_buffer_query #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W)
    ) u_query1 (
        .q_tag_i    (q1_tag),
        .cdb_valid_i(cdb_valid),
        .cdb_tag_i  (cdb_tag),
        .cdb_data_i (cdb_data),
        .busy_i     (busy_q),
        .ready_i    (ready_q),
        .data_i     (data_q),
        .q_ready_o  (q1_ready),
        .q_data_o   (q1_data)
    );

    reorder_buffer_query #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .DATA_W(DATA_W)
    ) u_query2 (
        .q_tag_i    (q2_tag),
        .cdb_valid_i(cdb_valid),
        .cdb_tag_i  (cdb_tag),
        .cdb_data_i (cdb_data),
        .busy_i     (busy_q),
        .ready_i    (ready_q),
        .data_i     (data_q),
        .q_ready_o  (q2_ready),
        .q_data_o   (q2_data)
    );

endmodule
